gallery_slot_controller: RTL and testbench
==========================================

Name: gallery_slot_controller

Overview:
Sequences the image-slot datapath behind the button front end. Consumes single-cycle next/prev/delete pulses, tracks which of NUM_SLOTS image slots are still valid, and steps the displayed index while skipping deleted slots. Issues a req/ack erase handshake to the framebuffer and provides an optional slideshow auto-advance. Sits between the debounced-button block and the image ROM/framebuffer read mux.

Parameters:
NUM_SLOTS, 4, number of image slots (power of two; IDX_W = log2(NUM_SLOTS))
SLIDE_TICKS, 100000000, clk cycles between slideshow advances (1 s at 100 MHz)
TIMER_W, 27, slideshow counter width (must hold SLIDE_TICKS-1)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low
next_pulse  in  1  single-cycle request to advance to the next valid slot
prev_pulse  in  1  single-cycle request to step back to the previous valid slot
delete_pulse  in  1  single-cycle request to delete the current slot
restore_all  in  1  single-cycle request to mark all slots valid
slideshow_en  in  1  level; enables auto-advance
erase_ack  in  1  framebuffer has finished erasing erase_index
cur_index  out  IDX_W  slot currently displayed
valid_mask  out  NUM_SLOTS  bit i = slot i holds an image
empty  out  1  no valid slots; display must blank
busy  out  1  high in SEARCH or ERASE; new events are dropped
erase_req  out  1  erase request, held until acknowledged
erase_index  out  IDX_W  slot to erase, stable while erase_req is high

Behaviour:
- Reset (async, reset_n=0): cur_index=0, valid_mask=all ones, empty=0, busy=0, erase_req=0, erase_index=0, state=IDLE, slide timer=0.
- States: IDLE, SEARCH, ERASE. busy = (state != IDLE).
- IDLE event priority when several inputs are high in the same cycle: restore_all > delete_pulse > next_pulse > prev_pulse > slide tick. Only the winning event is acted on; the others are dropped. All events are ignored outside IDLE.
- restore_all: valid_mask <= all ones, empty <= 0, cur_index unchanged, stay in IDLE. Takes 1 cycle.
- next/prev (ignored when empty=1):
  - Load cand = cur_index +/- 1 (mod NUM_SLOTS), set dir, go to SEARCH.
  - SEARCH checks one candidate per cycle. If valid_mask[cand]=1: cur_index <= cand and go to IDLE. Otherwise cand <= cand + dir.
  - Wrap-around is modulo NUM_SLOTS. At most NUM_SLOTS candidates are checked, and the last one is the original cur_index.
  - If a single valid slot exists and it is the current slot, cur_index is unchanged after NUM_SLOTS checks.
  - Latency: cur_index changes k+1 cycles after the pulse, where k is the number of candidates checked (1..NUM_SLOTS).
- delete (ignored when empty=1):
  - Go to ERASE with erase_req=1 and erase_index=cur_index, both registered on the next edge.
  - Hold erase_req until erase_ack is sampled high. On that edge: erase_req <= 0, valid_mask[erase_index] <= 0, cand <= cur_index+1, dir=+1, go to SEARCH.
  - erase_ack seen outside ERASE is ignored.
- SEARCH exhausted (NUM_SLOTS candidates, none valid): empty <= 1, cur_index unchanged, go to IDLE.
- Slide timer:
  - Counts only when slideshow_en=1, state=IDLE, and empty=0.
  - Clears to 0 on any accepted user event, when slideshow_en=0, or when not counting.
  - When the count reaches SLIDE_TICKS-1, emits an internal tick (treated as next_pulse) and wraps to 0.
- Reset asserted mid-ERASE or mid-SEARCH: all outputs go to their reset values immediately. No erase completion is recorded.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
1. Reset, then next_pulse ×5 with all slots valid → cur_index sequence 1,2,3,0,1. Each step lands 2 cycles after its pulse; busy high for 1 cycle per step.
2. valid_mask=1011 (slot 2 deleted), cur=1, next_pulse → cur_index=3 after 3 cycles. Then prev_pulse → cur_index=1 (slot 2 skipped).
3. cur=2, delete_pulse, erase_ack delayed 10 cycles → erase_req=1 with erase_index=2 for exactly the cycles until ack; valid_mask[2]=0 afterwards; cur_index=3; busy=1 throughout.
4. Delete slots until one remains (slot 0), then delete slot 0 → empty=1, valid_mask=0000, cur_index=0. next/prev/delete are then ignored. restore_all → valid_mask=1111, empty=0.
5. next_pulse and prev_pulse high in the same cycle (cur=1) → cur_index=2. next_pulse during ERASE → dropped, cur_index follows the delete search only.
6. SLIDE_TICKS=8, slideshow_en=1 → cur_index advances every 8 IDLE cycles. A next_pulse mid-count restarts the timer. Pulsing reset_n low mid-ERASE → erase_req=0, valid_mask=1111, cur_index=0 asynchronously.

Source files
------------

// File: rtl/gallery_slot_controller_if.sv
// Bundle of event, status and erase-handshake signals between the button
// front end / framebuffer side (master) and the slot controller (slave).
interface gallery_slot_controller_if #(
    parameter int NUM_SLOTS = 4
);
    localparam int IDX_W = $clog2(NUM_SLOTS);

    // Single-cycle events and level controls from the front end
    logic                 next_pulse;
    logic                 prev_pulse;
    logic                 delete_pulse;
    logic                 restore_all;
    logic                 slideshow_en;

    // Erase handshake with the framebuffer
    logic                 erase_req;
    logic                 erase_ack;
    logic [IDX_W-1:0]     erase_index;

    // Display status
    logic [IDX_W-1:0]     cur_index;
    logic [NUM_SLOTS-1:0] valid_mask;
    logic                 empty;
    logic                 busy;

    modport master (
        output next_pulse, prev_pulse, delete_pulse, restore_all, slideshow_en,
        output erase_ack,
        input  erase_req, erase_index,
        input  cur_index, valid_mask, empty, busy
    );

    modport slave (
        input  next_pulse, prev_pulse, delete_pulse, restore_all, slideshow_en,
        input  erase_ack,
        output erase_req, erase_index,
        output cur_index, valid_mask, empty, busy
    );
endinterface

// File: rtl/gallery_slot_controller.sv
// Image-slot sequencer: steps the displayed slot forward/back skipping
// deleted slots, runs the erase handshake with the framebuffer and
// generates the slideshow auto-advance. All outputs come from flops.
module gallery_slot_controller #(
    parameter int NUM_SLOTS   = 4,
    parameter int SLIDE_TICKS = 100000000,
    parameter int TIMER_W     = 27
) (
    input  logic                          clk,
    input  logic                          reset_n,
    gallery_slot_controller_if.slave      bus
);

    localparam int IDX_W = $clog2(NUM_SLOTS);
    localparam logic [TIMER_W-1:0] TICK_LAST  = TIMER_W'(SLIDE_TICKS - 1);
    // Index of the final candidate a search may inspect (the original slot)
    localparam logic [IDX_W-1:0]   LAST_CHECK = IDX_W'(NUM_SLOTS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_ERASE  = 2'd2
    } state_t;

    state_t               r_state;
    logic [IDX_W-1:0]     r_cur_index;
    logic [NUM_SLOTS-1:0] r_valid_mask;
    logic                 r_empty;
    logic                 r_busy;
    logic                 r_erase_req;
    logic [IDX_W-1:0]     r_erase_index;
    logic [IDX_W-1:0]     r_cand;
    logic                 r_dir_down;
    logic [IDX_W-1:0]     r_checks;
    logic [TIMER_W-1:0]   r_timer;

    state_t               w_state_next;
    logic [IDX_W-1:0]     w_cur_index_next;
    logic [NUM_SLOTS-1:0] w_valid_mask_next;
    logic                 w_empty_next;
    logic                 w_erase_req_next;
    logic [IDX_W-1:0]     w_erase_index_next;
    logic [IDX_W-1:0]     w_cand_next;
    logic                 w_dir_down_next;
    logic [IDX_W-1:0]     w_checks_next;
    logic [TIMER_W-1:0]   w_timer_next;
    logic                 w_tick;
    logic                 w_step_down;

    // Next-state and datapath decode for IDLE / SEARCH / ERASE
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        w_state_next       = r_state;
        w_cur_index_next   = r_cur_index;
        w_valid_mask_next  = r_valid_mask;
        w_empty_next       = r_empty;
        w_erase_req_next   = r_erase_req;
        w_erase_index_next = r_erase_index;
        w_cand_next        = r_cand;
        w_dir_down_next    = r_dir_down;
        w_checks_next      = r_checks;
        w_timer_next       = '0;
        w_tick             = 1'b0;
        w_step_down        = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_tick = bus.slideshow_en && !r_empty && (r_timer == TICK_LAST);
                if (bus.restore_all) begin
                    w_valid_mask_next = '1;
                    w_empty_next      = 1'b0;
                end else if (!r_empty && bus.delete_pulse) begin
                    w_state_next       = S_ERASE;
                    w_erase_req_next   = 1'b1;
                    w_erase_index_next = r_cur_index;
                end else if (!r_empty && (bus.next_pulse || bus.prev_pulse || w_tick)) begin
                    // next outranks prev; the slideshow tick behaves like next
                    w_step_down     = !bus.next_pulse && bus.prev_pulse;
                    w_dir_down_next = w_step_down;
                    w_cand_next     = w_step_down ? r_cur_index - IDX_W'(1)
                                                  : r_cur_index + IDX_W'(1);
                    w_checks_next   = '0;
                    w_state_next    = S_SEARCH;
                end else if (bus.slideshow_en && !r_empty) begin
                    w_timer_next = r_timer + TIMER_W'(1);
                end
            end

            S_SEARCH: begin
                if (r_valid_mask[r_cand]) begin
                    w_cur_index_next = r_cand;
                    w_state_next     = S_IDLE;
                end else if (r_checks == LAST_CHECK) begin
                    // Every slot, including the current one, is invalid
                    w_empty_next = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_cand_next   = r_dir_down ? r_cand - IDX_W'(1) : r_cand + IDX_W'(1);
                    w_checks_next = r_checks + IDX_W'(1);
                end
            end

            S_ERASE: begin
                if (bus.erase_ack) begin
                    w_erase_req_next                  = 1'b0;
                    w_valid_mask_next[r_erase_index]  = 1'b0;
                    w_cand_next                       = r_cur_index + IDX_W'(1);
                    w_dir_down_next                   = 1'b0;
                    w_checks_next                     = '0;
                    w_state_next                      = S_SEARCH;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_cur_index   <= '0;
            r_valid_mask  <= '1;
            r_empty       <= 1'b0;
            r_busy        <= 1'b0;
            r_erase_req   <= 1'b0;
            r_erase_index <= '0;
            r_cand        <= '0;
            r_dir_down    <= 1'b0;
            r_checks      <= '0;
            r_timer       <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
            r_state       <= w_state_next;
            r_cur_index   <= w_cur_index_next;
            r_valid_mask  <= w_valid_mask_next;
            r_empty       <= w_empty_next;
            r_busy        <= (w_state_next != S_IDLE);
            r_erase_req   <= w_erase_req_next;
            r_erase_index <= w_erase_index_next;
            r_cand        <= w_cand_next;
            r_dir_down    <= w_dir_down_next;
            r_checks      <= w_checks_next;
            r_timer       <= w_timer_next;
        end
    end

    assign bus.cur_index   = r_cur_index;
    assign bus.valid_mask  = r_valid_mask;
    assign bus.empty       = r_empty;
    assign bus.busy        = r_busy;
    assign bus.erase_req   = r_erase_req;
    assign bus.erase_index = r_erase_index;

endmodule

// File: tb/tb_gallery_slot_controller.sv
// Directed bench for gallery_slot_controller: 4 slots, slideshow period 8.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_gallery_slot_controller;

    localparam int NUM_SLOTS   = 4;
    localparam int SLIDE_TICKS = 8;
    localparam int TIMER_W     = 4;

    logic clk = 1'b0;
    logic reset_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    gallery_slot_controller_if #(.NUM_SLOTS(NUM_SLOTS)) bus ();

    gallery_slot_controller #(
        .NUM_SLOTS   (NUM_SLOTS),
        .SLIDE_TICKS (SLIDE_TICKS),
        .TIMER_W     (TIMER_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ev = {restore_all, delete_pulse, next_pulse, prev_pulse}, held for one cycle
    task automatic events(input logic [3:0] ev);
        bus.restore_all  = ev[3];
        bus.delete_pulse = ev[2];
        bus.next_pulse   = ev[1];
        bus.prev_pulse   = ev[0];
        @(negedge clk);
        bus.restore_all  = 1'b0;
        bus.delete_pulse = 1'b0;
        bus.next_pulse   = 1'b0;
        bus.prev_pulse   = 1'b0;
    endtask

    // Navigation event that checks k candidates before landing on new_cur
    task automatic step(input string tag, input logic [3:0] ev, input int k,
                        input int old_cur, input int new_cur);
        events(ev);
        cycles(k - 1);
        check({tag, " busy"}, bus.busy, 1);
        check({tag, " hold"}, bus.cur_index, old_cur);
        cycles(1);
        check({tag, " cur"}, bus.cur_index, new_cur);
        check({tag, " idle"}, bus.busy, 0);
    endtask

    // Delete current slot, acknowledge after ack_delay cycles, then search k candidates
    task automatic del(input string tag, input int ack_delay, input int erase_idx,
                       input int exp_mask, input int k, input int new_cur);
        int req_cycles;
        events(4'b0100);
        req_cycles = 0;
        for (int i = 0; i < ack_delay; i++) begin
            if (bus.erase_req === 1'b1 && bus.erase_index === 2'(erase_idx) && bus.busy === 1'b1)
                req_cycles++;
            cycles(1);
        end
        check({tag, " req held"}, req_cycles, ack_delay);
        check({tag, " req"}, bus.erase_req, 1);
        check({tag, " idx"}, bus.erase_index, erase_idx);
        bus.erase_ack = 1'b1;
        cycles(1);
        bus.erase_ack = 1'b0;
        check({tag, " req drop"}, bus.erase_req, 0);
        check({tag, " mask"}, bus.valid_mask, exp_mask);
        check({tag, " search busy"}, bus.busy, 1);
        cycles(k);
        check({tag, " cur"}, bus.cur_index, new_cur);
        check({tag, " idle"}, bus.busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.next_pulse   = 1'b0;
        bus.prev_pulse   = 1'b0;
        bus.delete_pulse = 1'b0;
        bus.restore_all  = 1'b0;
        bus.slideshow_en = 1'b0;
        bus.erase_ack    = 1'b0;
        reset_n          = 1'b0;

        // Reset values
        cycles(2);
        check("rst cur",   bus.cur_index,   0);
        check("rst mask",  bus.valid_mask,  4'hf);
        check("rst empty", bus.empty,       0);
        check("rst busy",  bus.busy,        0);
        check("rst req",   bus.erase_req,   0);
        check("rst eidx",  bus.erase_index, 0);
        reset_n = 1'b1;
        cycles(1);

        // Plain next stepping with every slot valid, including wrap 3 -> 0
        step("t1 n1", 4'b0010, 1, 0, 1);
        step("t1 n2", 4'b0010, 1, 1, 2);
        step("t1 n3", 4'b0010, 1, 2, 3);
        step("t1 n4", 4'b0010, 1, 3, 0);
        step("t1 n5", 4'b0010, 1, 0, 1);

        // Acknowledge outside ERASE has no effect
        bus.erase_ack = 1'b1;
        cycles(1);
        bus.erase_ack = 1'b0;
        check("stray ack mask", bus.valid_mask, 4'hf);
        check("stray ack busy", bus.busy, 0);
        check("stray ack req",  bus.erase_req, 0);

        // Delete slot 2 with a 10-cycle acknowledge delay
        step("t3 setup", 4'b0010, 1, 1, 2);
        del("t3 del2", 10, 2, 4'b1011, 1, 3);

        // Skip the deleted slot in both directions
        step("t2 prev", 4'b0001, 2, 3, 1);
        step("t2 next", 4'b0010, 2, 1, 3);

        // Restore, then next and prev together: next wins
        events(4'b1000);
        check("t5 restore mask", bus.valid_mask, 4'hf);
        check("t5 restore cur",  bus.cur_index, 3);
        check("t5 restore busy", bus.busy, 0);
        step("t5 p1", 4'b0001, 1, 3, 2);
        step("t5 p2", 4'b0001, 1, 2, 1);
        step("t5 next+prev", 4'b0011, 1, 1, 2);

        // delete outranks next; a next during ERASE is dropped
        events(4'b0110);
        check("t5 del+next req",  bus.erase_req, 1);
        check("t5 del+next eidx", bus.erase_index, 2);
        events(4'b0010);
        check("t5 drop req",  bus.erase_req, 1);
        check("t5 drop busy", bus.busy, 1);
        bus.erase_ack = 1'b1;
        cycles(1);
        bus.erase_ack = 1'b0;
        check("t5 drop mask", bus.valid_mask, 4'b1011);
        cycles(1);
        check("t5 drop cur", bus.cur_index, 3);
        cycles(2);
        check("t5 drop settle cur",  bus.cur_index, 3);
        check("t5 drop settle busy", bus.busy, 0);

        // restore outranks delete
        events(4'b1100);
        check("t5 rst+del mask", bus.valid_mask, 4'hf);
        check("t5 rst+del req",  bus.erase_req, 0);
        check("t5 rst+del busy", bus.busy, 0);

        // Delete down to slot 0, then delete it too
        del("t4 d3", 0, 3, 4'b0111, 1, 0);
        step("t4 n", 4'b0010, 1, 0, 1);
        del("t4 d1", 0, 1, 4'b0101, 1, 2);
        del("t4 d2", 0, 2, 4'b0001, 2, 0);
        del("t4 d0", 0, 0, 4'b0000, 4, 0);
        check("t4 empty", bus.empty, 1);

        // Navigation and delete ignored while empty
        events(4'b0010);
        check("t4 ign next busy", bus.busy, 0);
        events(4'b0001);
        check("t4 ign prev busy", bus.busy, 0);
        events(4'b0100);
        check("t4 ign del req",  bus.erase_req, 0);
        check("t4 ign del busy", bus.busy, 0);
        check("t4 ign cur",      bus.cur_index, 0);
        check("t4 ign mask",     bus.valid_mask, 0);
        events(4'b1000);
        check("t4 restore mask",  bus.valid_mask, 4'hf);
        check("t4 restore empty", bus.empty, 0);

        // Slideshow: 8 IDLE cycles, then a 1-cycle search
        bus.slideshow_en = 1'b1;
        cycles(7);
        check("t6 pre tick busy", bus.busy, 0);
        check("t6 pre tick cur",  bus.cur_index, 0);
        cycles(1);
        check("t6 tick1 busy", bus.busy, 1);
        cycles(1);
        check("t6 tick1 cur", bus.cur_index, 1);
        cycles(8);
        check("t6 tick2 busy", bus.busy, 1);
        cycles(1);
        check("t6 tick2 cur", bus.cur_index, 2);

        // A next part-way through the count restarts the timer
        cycles(4);
        step("t6 next", 4'b0010, 1, 2, 3);
        cycles(7);
        check("t6 restart hold busy", bus.busy, 0);
        check("t6 restart hold cur",  bus.cur_index, 3);
        cycles(1);
        check("t6 restart tick busy", bus.busy, 1);
        cycles(1);
        check("t6 restart tick cur", bus.cur_index, 0);
        bus.slideshow_en = 1'b0;
        cycles(12);
        check("t6 disabled cur",  bus.cur_index, 0);
        check("t6 disabled busy", bus.busy, 0);

        // Asynchronous reset in the middle of an erase
        step("t6 pre del", 4'b0010, 1, 0, 1);
        events(4'b0100);
        check("t6 erase req",  bus.erase_req, 1);
        check("t6 erase eidx", bus.erase_index, 1);
        cycles(2);
        #2 reset_n = 1'b0;
        #1;
        check("t6 async req",  bus.erase_req, 0);
        check("t6 async mask", bus.valid_mask, 4'hf);
        check("t6 async cur",  bus.cur_index, 0);
        check("t6 async busy", bus.busy, 0);
        check("t6 async eidx", bus.erase_index, 0);
        @(negedge clk);
        reset_n = 1'b1;
        bus.erase_ack = 1'b1;
        cycles(1);
        bus.erase_ack = 1'b0;
        cycles(1);
        check("t6 post rst mask", bus.valid_mask, 4'hf);
        check("t6 post rst busy", bus.busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
